// File: rtl/mem2axil_master_pkg.sv
// Shared definitions for the native-memory to AXI4-Lite initiator:
// state encodings, AXI response codes, protection values and the
// read data returned when a response never arrives.
package mem2axil_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WADDR = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DATA  = 3'b000;
  localparam logic [2:0] PROT_INSTR = 3'b100;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  // Both error responses have bit 1 set; OKAY/EXOKAY are successes.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/mem2axil_master.sv
// Single-outstanding AXI4-Lite initiator driven by a picorv32-style
// native memory port (valid/ready, wstrb != 0 means write).
// Optional response-wait timeout: define MEM2AXIL_TIMEOUT_EN.
module mem2axil_master
  import mem2axil_master_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    mem_valid_i,
  input  logic                    mem_instr_i,
  input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
  input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] mem_wstrb_i,
  output logic                    mem_ready_o,
  output logic [DATA_WIDTH-1:0]   mem_rdata_o,
  output logic                    mem_err_o,
  output logic                    mem_axi_awvalid,
  input  logic                    mem_axi_awready,
  output logic [ADDR_WIDTH-1:0]   mem_axi_awaddr,
  output logic [2:0]              mem_axi_awprot,
  output logic                    mem_axi_wvalid,
  input  logic                    mem_axi_wready,
  output logic [DATA_WIDTH-1:0]   mem_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_axi_wstrb,
  input  logic                    mem_axi_bvalid,
  output logic                    mem_axi_bready,
  input  logic [1:0]              mem_axi_bresp,
  output logic                    mem_axi_arvalid,
  input  logic                    mem_axi_arready,
  output logic [ADDR_WIDTH-1:0]   mem_axi_araddr,
  output logic [2:0]              mem_axi_arprot,
  input  logic                    mem_axi_rvalid,
  output logic                    mem_axi_rready,
  input  logic [DATA_WIDTH-1:0]   mem_axi_rdata,
  input  logic [1:0]              mem_axi_rresp
);

  // Reject configurations the datapath cannot honour.
  if (DATA_WIDTH != 32 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("mem2axil_master: DATA_WIDTH must be 32 and TIMEOUT_CYC >= 2");
  end

  state_t state_reg, state_next;

  logic                    awvalid_reg, awvalid_next;
  logic                    wvalid_reg,  wvalid_next;
  logic                    bready_reg,  bready_next;
  logic                    arvalid_reg, arvalid_next;
  logic                    rready_reg,  rready_next;
  logic                    ready_reg,   ready_next;
  logic                    err_reg,     err_next;
  logic [ADDR_WIDTH-1:0]   addr_reg,    addr_next;
  logic [DATA_WIDTH-1:0]   wdata_reg,   wdata_next;
  logic [DATA_WIDTH/8-1:0] wstrb_reg,   wstrb_next;
  logic [2:0]              arprot_reg,  arprot_next;
  logic [DATA_WIDTH-1:0]   rdata_reg,   rdata_next;

  // A write channel is finished once its valid has dropped or is being accepted now.
  logic aw_done, w_done;
  assign aw_done = !awvalid_reg || mem_axi_awready;
  assign w_done  = !wvalid_reg  || mem_axi_wready;

  logic timeout_hit;

`ifdef MEM2AXIL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_reg;
  logic             waiting;
  logic             completing;

  assign waiting    = (state_reg == ST_WADDR) || (state_reg == ST_WRESP) ||
                      (state_reg == ST_RADDR) || (state_reg == ST_RDATA);
  // A response arriving in the last allowed cycle still wins over the timeout.
  assign completing = ((state_reg == ST_WRESP) && mem_axi_bvalid) ||
                      ((state_reg == ST_RDATA) && mem_axi_rvalid);
  assign timeout_hit = waiting && !completing && (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

  // Wait counter: held at zero in IDLE so it starts fresh for every transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
    end else if (state_reg == ST_IDLE) begin
      cnt_reg <= '0;
    end else if (waiting) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= ST_IDLE;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      bready_reg  <= 1'b0;
      arvalid_reg <= 1'b0;
      rready_reg  <= 1'b0;
      ready_reg   <= 1'b0;
      err_reg     <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      arprot_reg  <= PROT_DATA;
      rdata_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      awvalid_reg <= awvalid_next;
      wvalid_reg  <= wvalid_next;
      bready_reg  <= bready_next;
      arvalid_reg <= arvalid_next;
      rready_reg  <= rready_next;
      ready_reg   <= ready_next;
      err_reg     <= err_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      wstrb_reg   <= wstrb_next;
      arprot_reg  <= arprot_next;
      rdata_reg   <= rdata_next;
    end
  end

  // Next-state logic; DONE always returns to IDLE so a held valid is not re-accepted.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (mem_valid_i) state_next = (mem_wstrb_i != '0) ? ST_WADDR : ST_RADDR;
      ST_WADDR: if (aw_done && w_done) state_next = ST_WRESP;
      ST_WRESP: if (mem_axi_bvalid) state_next = ST_DONE;
      ST_RADDR: if (mem_axi_arready) state_next = ST_RDATA;
      ST_RDATA: if (mem_axi_rvalid) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (timeout_hit) state_next = ST_DONE;
  end

  // Next values of the registered outputs; request fields are latched only on acceptance.
  always_comb begin
    awvalid_next = awvalid_reg;
    wvalid_next  = wvalid_reg;
    bready_next  = bready_reg;
    arvalid_next = arvalid_reg;
    rready_next  = rready_reg;
    ready_next   = 1'b0;
    err_next     = err_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    wstrb_next   = wstrb_reg;
    arprot_next  = arprot_reg;
    rdata_next   = rdata_reg;
    case (state_reg)
      ST_IDLE: begin
        if (mem_valid_i) begin
          addr_next = mem_addr_i;
          if (mem_wstrb_i != '0) begin
            wdata_next   = mem_wdata_i;
            wstrb_next   = mem_wstrb_i;
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
          end else begin
            arprot_next  = mem_instr_i ? PROT_INSTR : PROT_DATA;
            arvalid_next = 1'b1;
          end
        end
      end
      ST_WADDR: begin
        if (mem_axi_awready) awvalid_next = 1'b0;
        if (mem_axi_wready)  wvalid_next  = 1'b0;
        if (aw_done && w_done) bready_next = 1'b1;
      end
      ST_WRESP: begin
        if (mem_axi_bvalid) begin
          bready_next = 1'b0;
          err_next    = resp_is_err(mem_axi_bresp);
          ready_next  = 1'b1;
        end
      end
      ST_RADDR: begin
        if (mem_axi_arready) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
        end
      end
      ST_RDATA: begin
        if (mem_axi_rvalid) begin
          rdata_next  = mem_axi_rdata;
          err_next    = resp_is_err(mem_axi_rresp);
          rready_next = 1'b0;
          ready_next  = 1'b1;
        end
      end
      default: begin
      end
    endcase
    if (timeout_hit) begin
      awvalid_next = 1'b0;
      wvalid_next  = 1'b0;
      bready_next  = 1'b0;
      arvalid_next = 1'b0;
      rready_next  = 1'b0;
      ready_next   = 1'b1;
      err_next     = 1'b1;
      rdata_next   = TIMEOUT_RDATA;
    end
  end

  assign mem_ready_o     = ready_reg;
  assign mem_rdata_o     = rdata_reg;
  assign mem_err_o       = err_reg;
  assign mem_axi_awvalid = awvalid_reg;
  assign mem_axi_awaddr  = addr_reg;
  assign mem_axi_awprot  = PROT_DATA;
  assign mem_axi_wvalid  = wvalid_reg;
  assign mem_axi_wdata   = wdata_reg;
  assign mem_axi_wstrb   = wstrb_reg;
  assign mem_axi_bready  = bready_reg;
  assign mem_axi_arvalid = arvalid_reg;
  assign mem_axi_araddr  = addr_reg;
  assign mem_axi_arprot  = arprot_reg;
  assign mem_axi_rready  = rready_reg;

endmodule

// File: tb/tb_mem2axil_master.sv
// Self-checking bench for mem2axil_master: directed scenarios plus random
// transactions against a slave with random per-channel wait states.
module tb_mem2axil_master;
  import mem2axil_master_pkg::*;

  localparam int TCYC = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mem_valid_i, mem_instr_i;
  logic [31:0] mem_addr_i, mem_wdata_i;
  logic [3:0]  mem_wstrb_i;
  logic        mem_ready_o, mem_err_o;
  logic [31:0] mem_rdata_o;
  logic        mem_axi_awvalid, mem_axi_awready;
  logic [31:0] mem_axi_awaddr;
  logic [2:0]  mem_axi_awprot;
  logic        mem_axi_wvalid, mem_axi_wready;
  logic [31:0] mem_axi_wdata;
  logic [3:0]  mem_axi_wstrb;
  logic        mem_axi_bvalid, mem_axi_bready;
  logic [1:0]  mem_axi_bresp;
  logic        mem_axi_arvalid, mem_axi_arready;
  logic [31:0] mem_axi_araddr;
  logic [2:0]  mem_axi_arprot;
  logic        mem_axi_rvalid, mem_axi_rready;
  logic [31:0] mem_axi_rdata;
  logic [1:0]  mem_axi_rresp;

  always #5 clk_i = ~clk_i;

  mem2axil_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYC(TCYC)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_valid_i(mem_valid_i), .mem_instr_i(mem_instr_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_wstrb_i(mem_wstrb_i),
    .mem_ready_o(mem_ready_o), .mem_rdata_o(mem_rdata_o), .mem_err_o(mem_err_o),
    .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awready(mem_axi_awready),
    .mem_axi_awaddr(mem_axi_awaddr), .mem_axi_awprot(mem_axi_awprot),
    .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wready(mem_axi_wready),
    .mem_axi_wdata(mem_axi_wdata), .mem_axi_wstrb(mem_axi_wstrb),
    .mem_axi_bvalid(mem_axi_bvalid), .mem_axi_bready(mem_axi_bready), .mem_axi_bresp(mem_axi_bresp),
    .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_arready(mem_axi_arready),
    .mem_axi_araddr(mem_axi_araddr), .mem_axi_arprot(mem_axi_arprot),
    .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(mem_axi_rready),
    .mem_axi_rdata(mem_axi_rdata), .mem_axi_rresp(mem_axi_rresp)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_slave();
    mem_axi_awready = 1'b0; mem_axi_wready = 1'b0; mem_axi_arready = 1'b0;
    mem_axi_bvalid  = 1'b0; mem_axi_bresp  = 2'b00;
    mem_axi_rvalid  = 1'b0; mem_axi_rresp  = 2'b00; mem_axi_rdata = 32'h0;
  endtask

  // Idle cycles with random garbage on every slave input: nothing may start or complete.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      mem_valid_i     = 1'b0;
      mem_axi_awready = 1'($urandom_range(0, 1));
      mem_axi_wready  = 1'($urandom_range(0, 1));
      mem_axi_arready = 1'($urandom_range(0, 1));
      mem_axi_bvalid  = 1'($urandom_range(0, 1));
      mem_axi_bresp   = 2'($urandom_range(0, 3));
      mem_axi_rvalid  = 1'($urandom_range(0, 1));
      mem_axi_rresp   = 2'($urandom_range(0, 3));
      mem_axi_rdata   = $urandom;
      @(negedge clk_i);
      chk("idle_quiet", {26'b0, mem_axi_awvalid, mem_axi_wvalid, mem_axi_bready,
                         mem_axi_arvalid, mem_axi_rready, mem_ready_o}, 32'h0);
      chk("idle_rdata_hold", mem_rdata_o, model_rdata);
    end
    clear_slave();
  endtask

  // One CPU transaction against a slave that waits the given number of cycles per channel.
  // Expected completion cycle: 3 + address wait (max of AW/W for writes) + response wait.
  task automatic run_txn(input bit wr, input bit instr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input int aw_d, input int w_d, input int ar_d, input int rsp_d,
                         input logic [31:0] rd, input logic [1:0] rsp, input int extra);
    int lat, k, aw_c, w_c, ar_c, rs_c;
    bit aw_hs, w_hs, ar_hs, rs_hs, done, to;
    logic [31:0] exp_rd;
    logic        exp_err;
    string       nm;
    nm  = wr ? "wr" : "rd";
    lat = wr ? 3 + ((aw_d > w_d) ? aw_d : w_d) + rsp_d : 3 + ar_d + rsp_d;
    to  = 1'b0;
`ifdef MEM2AXIL_TIMEOUT_EN
    if (lat - 1 > TCYC) begin
      to  = 1'b1;
      lat = TCYC + 1;
    end
`endif
    lat     = lat + extra;
    exp_err = to ? 1'b1 : rsp[1];
    exp_rd  = to ? 32'hDEAD_BEEF : (wr ? model_rdata : rd);
    mem_valid_i = 1'b1; mem_instr_i = instr; mem_addr_i = addr;
    mem_wdata_i = wdata; mem_wstrb_i = wr ? strb : 4'h0;
    aw_c = 0; w_c = 0; ar_c = 0; rs_c = 0;
    aw_hs = 0; w_hs = 0; ar_hs = 0; rs_hs = 0; done = 0; k = 0;
    while (!done && k < 300) begin
      @(negedge clk_i);
      k++;
      if (mem_ready_o) begin
        done = 1'b1;
        chk({nm, "_latency"}, k, lat);
        chk({nm, "_err"}, {31'b0, mem_err_o}, {31'b0, exp_err});
        chk({nm, "_rdata"}, mem_rdata_o, exp_rd);
        chk({nm, "_quiet_at_done"}, {27'b0, mem_axi_awvalid, mem_axi_wvalid, mem_axi_bready,
                                     mem_axi_arvalid, mem_axi_rready}, 32'h0);
        if (!to) chk({nm, "_resp_handshake"}, {31'b0, rs_hs}, 32'h1);
        model_rdata = exp_rd;
        mem_valid_i = 1'b0;
        clear_slave();
      end else begin
        if (mem_axi_bready) begin
          chk("b_after_aw_and_w", {30'b0, aw_hs, w_hs}, 32'h3);
          mem_axi_bvalid = (rs_c >= rsp_d);
          mem_axi_bresp  = rsp;
          rs_c++;
          if (mem_axi_bvalid) rs_hs = 1'b1;
        end else begin
          mem_axi_bvalid = 1'b0;
        end
        if (mem_axi_rready) begin
          chk("r_after_ar", {31'b0, ar_hs}, 32'h1);
          mem_axi_rvalid = (rs_c >= rsp_d);
          mem_axi_rresp  = rsp;
          mem_axi_rdata  = mem_axi_rvalid ? rd : $urandom;
          rs_c++;
          if (mem_axi_rvalid) rs_hs = 1'b1;
        end else begin
          mem_axi_rvalid = 1'b0;
        end
        if (mem_axi_awvalid) begin
          chk("aw_single", {31'b0, aw_hs}, 32'h0);
          chk("awaddr", mem_axi_awaddr, addr);
          chk("awprot", {29'b0, mem_axi_awprot}, 32'h0);
          mem_axi_awready = (aw_c >= aw_d);
          aw_c++;
          if (mem_axi_awready) aw_hs = 1'b1;
        end else begin
          mem_axi_awready = 1'($urandom_range(0, 1));
        end
        if (mem_axi_wvalid) begin
          chk("w_single", {31'b0, w_hs}, 32'h0);
          chk("wdata", mem_axi_wdata, wdata);
          chk("wstrb", {28'b0, mem_axi_wstrb}, {28'b0, strb});
          mem_axi_wready = (w_c >= w_d);
          w_c++;
          if (mem_axi_wready) w_hs = 1'b1;
        end else begin
          mem_axi_wready = 1'($urandom_range(0, 1));
        end
        if (mem_axi_arvalid) begin
          chk("ar_single", {31'b0, ar_hs}, 32'h0);
          chk("araddr", mem_axi_araddr, addr);
          chk("arprot", {29'b0, mem_axi_arprot}, {29'b0, instr, 2'b00});
          mem_axi_arready = (ar_c >= ar_d);
          ar_c++;
          if (mem_axi_arready) ar_hs = 1'b1;
        end else begin
          mem_axi_arready = 1'($urandom_range(0, 1));
        end
      end
    end
    chk({nm, "_completed"}, {31'b0, done}, 32'h1);
  endtask

  bit found;
  bit rwr;

  initial begin
    rst_i = 1'b1; mem_valid_i = 1'b0; mem_instr_i = 1'b0;
    mem_addr_i = 32'h0; mem_wdata_i = 32'h0; mem_wstrb_i = 4'h0;
    clear_slave();
    model_rdata = 32'h0;
    repeat (3) @(negedge clk_i);
    chk("reset_quiet", {25'b0, mem_axi_awvalid, mem_axi_wvalid, mem_axi_bready, mem_axi_arvalid,
                        mem_axi_rready, mem_ready_o, mem_err_o}, 32'h0);
    chk("reset_rdata", mem_rdata_o, 32'h0);
    chk("reset_addr", mem_axi_awaddr | mem_axi_araddr, 32'h0);
    chk("reset_wdata_strb_prot", mem_axi_wdata | {28'b0, mem_axi_wstrb} |
                                 {26'b0, mem_axi_awprot, mem_axi_arprot}, 32'h0);
    rst_i = 1'b0;
    idle(3);

    // Zero-wait read.
    run_txn(0, 0, 32'h0300_7004, 32'h0, 4'h0, 0, 0, 0, 0, 32'h1234_5678, AXI_RESP_OKAY, 0);
    idle(2);
    // Write with wready accepted three cycles before awready.
    run_txn(1, 0, 32'h3000_0010, 32'hA5A5_0F0F, 4'hC, 3, 0, 0, 0, 32'h0, AXI_RESP_OKAY, 0);
    idle(2);
    // Instruction fetch returning SLVERR.
    run_txn(0, 1, 32'h0000_0100, 32'h0, 4'h0, 0, 0, 1, 2, 32'hCAFE_F00D, AXI_RESP_SLVERR, 0);
    idle(1);
    // Write with DECERR and awready before wready.
    run_txn(1, 0, 32'h3000_0020, 32'h0102_0304, 4'h1, 0, 2, 0, 1, 32'h0, AXI_RESP_DECERR, 0);
    idle(1);
    // Back-to-back reads: the second request is presented while the first is in DONE.
    run_txn(0, 0, 32'h0000_2000, 32'h0, 4'h0, 0, 0, 0, 0, 32'h1111_2222, AXI_RESP_OKAY, 0);
    run_txn(0, 0, 32'h0000_2004, 32'h0, 4'h0, 0, 0, 0, 0, 32'h3333_4444, AXI_RESP_EXOKAY, 1);
    idle(2);

    // Reset while waiting in the read-data phase; a later rvalid must be ignored.
    mem_valid_i = 1'b1; mem_instr_i = 1'b0; mem_addr_i = 32'h0000_1000; mem_wstrb_i = 4'h0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (mem_axi_rready) begin
        found = 1'b1;
        break;
      end
      mem_axi_arready = mem_axi_arvalid;
    end
    chk("rst_reached_rdata", {31'b0, found}, 32'h1);
    rst_i = 1'b1; mem_axi_arready = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0; mem_valid_i = 1'b0;
    chk("rst_mid_quiet", {25'b0, mem_axi_awvalid, mem_axi_wvalid, mem_axi_bready, mem_axi_arvalid,
                          mem_axi_rready, mem_ready_o, mem_err_o}, 32'h0);
    chk("rst_mid_rdata", mem_rdata_o, 32'h0);
    model_rdata = 32'h0;
    idle(4);

`ifdef MEM2AXIL_TIMEOUT_EN
    // Slave never accepts the read address.
    run_txn(0, 0, 32'h0400_0000, 32'h0, 4'h0, 0, 0, 1000, 0, 32'h0, AXI_RESP_OKAY, 0);
    idle(2);
`endif

    // Random traffic with short wait states.
    for (int t = 0; t < 24; t++) begin
      rwr = 1'($urandom_range(0, 1));
      run_txn(rwr, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(1, 15)),
              $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 3), $urandom, 2'($urandom_range(0, 3)), 0);
      idle($urandom_range(1, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
